enigma_key_ctrl: RTL and testbench

Keystroke controller for the Enigma datapath: it owns the three rotor position counters and steps them odometer-style on every accepted letter. It then sequences the letter through a seven-pass path (right→middle→left rotor forward, reflector, left→middle→right rotor backward), using one shared rotor-substitution unit time-multiplexed across all six rotor passes. It sits between the keyboard input stage and the lampboard output stage and exchanges letters with both over valid/ready handshakes.

---
 rtl/enigma_pkg.sv | 63 ++++++
 rtl/enigma_key_ctrl_if.sv | 24 ++
 rtl/enigma_rotor_sub.sv | 30 +++
 rtl/enigma_key_ctrl.sv | 139 +++++++++++++
 tb/tb_enigma_key_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enigma_pkg.sv
// Shared types, rotor wirings and constants for the Enigma keystroke datapath.
// Tables are 0-based: entry i is the contact that position i is wired to.
package enigma_pkg;

    localparam logic [4:0] LETTER_MIN = 5'd1;
    localparam logic [4:0] LETTER_MAX = 5'd26;
    localparam logic [4:0] DEF_NOTCH0 = 5'd21;
    localparam logic [4:0] DEF_NOTCH1 = 5'd4;

    typedef enum logic [3:0] {
        ST_IDLE, ST_STEP, ST_FWD0, ST_FWD1, ST_FWD2,
        ST_REFL, ST_BWD2, ST_BWD1, ST_BWD0, ST_DONE
    } state_e;

    typedef enum logic [1:0] {ROT_III = 2'd0, ROT_II = 2'd1, ROT_I = 2'd2} rotor_e;
    typedef enum logic {DIR_FWD = 1'b0, DIR_BWD = 1'b1} dir_e;

    typedef logic [4:0] rtbl_t [26];

    localparam rtbl_t ROTOR_I = '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21,
        5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0,
        5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
    localparam rtbl_t ROTOR_I_INV = '{5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15,
        5'd21, 5'd25, 5'd1, 5'd4, 5'd2, 5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11,
        5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
    localparam rtbl_t ROTOR_II = '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20,
        5'd23, 5'd1, 5'd11, 5'd7, 5'd22, 5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13,
        5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
    localparam rtbl_t ROTOR_II_INV = '{5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11,
        5'd5, 5'd1, 5'd3, 5'd10, 5'd14, 5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13,
        5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18};
    localparam rtbl_t ROTOR_III = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15,
        5'd17, 5'd19, 5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0,
        5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    localparam rtbl_t ROTOR_III_INV = '{5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3,
        5'd16, 5'd4, 5'd20, 5'd5, 5'd21, 5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9,
        5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

    function automatic logic is_letter(logic [4:0] c);
        return (c >= LETTER_MIN) && (c <= LETTER_MAX);
    endfunction

    function automatic logic [4:0] clamp_pos(logic [4:0] p);
        return (p > 5'd25) ? 5'd0 : p;
    endfunction

    function automatic logic [4:0] inc_pos(logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [4:0] rotor_tbl(rotor_e r, dir_e d, logic [4:0] idx);
        logic [4:0] i;
        logic [4:0] v;
        i = (idx > 5'd25) ? 5'd0 : idx;
        case (r)
            ROT_I:   v = (d == DIR_FWD) ? ROTOR_I[i]   : ROTOR_I_INV[i];
            ROT_II:  v = (d == DIR_FWD) ? ROTOR_II[i]  : ROTOR_II_INV[i];
            default: v = (d == DIR_FWD) ? ROTOR_III[i] : ROTOR_III_INV[i];
        endcase
        return v;
    endfunction

endpackage

// File: rtl/enigma_key_ctrl_if.sv
// Keyboard-side and lampboard-side handshakes plus rotor load/observe signals.
// master = keyboard/lampboard environment, slave = key controller.
interface enigma_key_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_letter;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_letter;
    logic        load;
    logic [14:0] load_pos;
    logic [14:0] pos;
    logic        err;

    modport master (
        output in_valid, in_letter, out_ready, load, load_pos,
        input  in_ready, out_valid, out_letter, pos, err
    );

    modport slave (
        input  in_valid, in_letter, out_ready, load, load_pos,
        output in_ready, out_valid, out_letter, pos, err
    );
endinterface

// File: rtl/enigma_rotor_sub.sv
// Single rotor pass: offset by position, look up forward or inverse wiring, undo offset.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module enigma_rotor_sub
    import enigma_pkg::*;
(
    input  logic [4:0] letter,
    input  logic [4:0] position,
    input  rotor_e     rotor,
    input  dir_e       dir,
    output logic [4:0] result
);

    logic [5:0] idx_raw;
    logic [4:0] idx;
    logic [4:0] tap;
    logic [5:0] diff_raw;
    logic [4:0] diff;

    // letter is 1-based, tables are 0-based; both mod-26 wraps need only one subtract
    always_comb begin
        idx_raw  = {1'b0, letter} + {1'b0, position} - 6'd1;
        idx      = (idx_raw >= 6'd26) ? 5'(idx_raw - 6'd26) : idx_raw[4:0];
        tap      = rotor_tbl(rotor, dir, idx);
        diff_raw = {1'b0, tap} + 6'd26 - {1'b0, position};
        diff     = (diff_raw >= 6'd26) ? 5'(diff_raw - 6'd26) : diff_raw[4:0];
        result   = diff + 5'd1;
    end

endmodule

// File: rtl/enigma_key_ctrl.sv
// Keystroke controller: steps rotors, then runs 7 passes through one shared rotor unit (ENIGMA_DOUBLE_STEP_EN enables double-step).
// Latency: out_valid rises 9 cycles after the acceptance cycle; one letter per 10 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready low whenever not IDLE.
module enigma_key_ctrl
    import enigma_pkg::*;
#(
    parameter logic [4:0] NOTCH0 = DEF_NOTCH0,
    parameter logic [4:0] NOTCH1 = DEF_NOTCH1
) (
    input logic               clk,
    input logic               rst,
    enigma_key_ctrl_if.slave  bus
);

    state_e      state_q, state_d;
    logic [4:0]  w_q, w_d;
    logic [14:0] pos_q, pos_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_letter_q, out_letter_d;
    logic        err_q, err_d;

    logic [4:0]  pos_l, pos_m, pos_r;
    logic        mid_step, left_step;
    rotor_e      sub_rotor;
    dir_e        sub_dir;
    logic [4:0]  sub_pos;
    logic [4:0]  sub_out;
    logic [4:0]  refl;

    assign pos_l = pos_q[14:10];
    assign pos_m = pos_q[9:5];
    assign pos_r = pos_q[4:0];

`ifdef ENIGMA_DOUBLE_STEP_EN
    // middle rotor sitting on its notch drags itself and the left rotor along
    assign mid_step  = (pos_r == NOTCH0) || (pos_m == NOTCH1);
    assign left_step = (pos_m == NOTCH1);
`else
    assign mid_step  = (pos_r == NOTCH0);
    assign left_step = mid_step && (pos_m == NOTCH1);
`endif

    assign refl = (w_q > 5'd13) ? w_q - 5'd13 : w_q + 5'd13;

    always_comb begin
        sub_rotor = ROT_III;
        sub_dir   = DIR_FWD;
        sub_pos   = pos_r;
        case (state_q)
            ST_FWD1, ST_BWD1: begin sub_rotor = ROT_II; sub_pos = pos_m; end
            ST_FWD2, ST_BWD2: begin sub_rotor = ROT_I;  sub_pos = pos_l; end
            default: ;
        endcase
        if (state_q == ST_BWD2 || state_q == ST_BWD1 || state_q == ST_BWD0)
            sub_dir = DIR_BWD;
    end

    enigma_rotor_sub u_sub (
        .letter   (w_q),
        .position (sub_pos),
        .rotor    (sub_rotor),
        .dir      (sub_dir),
        .result   (sub_out)
    );

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        pos_d        = pos_q;
        out_valid_d  = out_valid_q;
        out_letter_d = out_letter_q;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    pos_d = {clamp_pos(bus.load_pos[14:10]), clamp_pos(bus.load_pos[9:5]),
                             clamp_pos(bus.load_pos[4:0])};
                end else if (bus.in_valid) begin
                    if (is_letter(bus.in_letter)) begin
                        w_d     = bus.in_letter;
                        state_d = ST_STEP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                pos_d = {left_step ? inc_pos(pos_l) : pos_l,
                         mid_step  ? inc_pos(pos_m) : pos_m,
                         inc_pos(pos_r)};
                state_d = ST_FWD0;
            end
            ST_FWD0: begin w_d = sub_out; state_d = ST_FWD1; end
            ST_FWD1: begin w_d = sub_out; state_d = ST_FWD2; end
            ST_FWD2: begin w_d = sub_out; state_d = ST_REFL; end
            ST_REFL: begin w_d = refl;    state_d = ST_BWD2; end
            ST_BWD2: begin w_d = sub_out; state_d = ST_BWD1; end
            ST_BWD1: begin w_d = sub_out; state_d = ST_BWD0; end
            ST_BWD0: begin
                w_d          = sub_out;
                out_letter_d = sub_out;
                out_valid_d  = 1'b1;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            w_q          <= 5'd0;
            pos_q        <= 15'd0;
            out_valid_q  <= 1'b0;
            out_letter_q <= 5'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            pos_q        <= pos_d;
            out_valid_q  <= out_valid_d;
            out_letter_q <= out_letter_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_letter = out_letter_q;
    assign bus.pos        = pos_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_enigma_key_ctrl.sv
// Bench for enigma_key_ctrl: directed scenarios plus random keystrokes against a
// letter-string rotor model; outputs are matched by an independent monitor.
module tb_enigma_key_ctrl;

    localparam int NOTCH_R = 21;
    localparam int NOTCH_M = 4;

    typedef struct {
        int          letter;
        logic [14:0] pos;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    enigma_key_ctrl_if bus ();

    enigma_key_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   err_seen = 0;
    int   err_exp = 0;
    int   ml = 0, mm = 0, mr = 0;
    int   rdy_mode = 1;
    int   last_y = 0;
    bit   prev_vld = 0;
    int   held = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rmap(input int rot, input int x);
        string s;
        case (rot)
            0:       s = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
            1:       s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
            default: s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
        endcase
        return int'(s[x]) - 65;
    endfunction

    function automatic int rinv(input int rot, input int x);
        for (int j = 0; j < 26; j++)
            if (rmap(rot, j) == x) return j;
        return 0;
    endfunction

    function automatic int rpass(input int rot, input int p, input int x, input bit bwd);
        int c;
        int t;
        c = (x + p) % 26;
        t = bwd ? rinv(rot, c) : rmap(rot, c);
        return (t - p + 26) % 26;
    endfunction

    function automatic int model_enc(input int letter);
        int x;
        x = letter - 1;
        x = rpass(0, mr, x, 0);
        x = rpass(1, mm, x, 0);
        x = rpass(2, ml, x, 0);
        x = (x + 13) % 26;
        x = rpass(2, ml, x, 1);
        x = rpass(1, mm, x, 1);
        x = rpass(0, mr, x, 1);
        return x + 1;
    endfunction

    task automatic model_step();
        bit mid, left;
`ifdef ENIGMA_DOUBLE_STEP_EN
        mid  = (mr == NOTCH_R) || (mm == NOTCH_M);
        left = (mm == NOTCH_M);
`else
        mid  = (mr == NOTCH_R);
        left = mid && (mm == NOTCH_M);
`endif
        mr = (mr + 1) % 26;
        if (mid)  mm = (mm + 1) % 26;
        if (left) ml = (ml + 1) % 26;
    endtask

    function automatic logic [14:0] mpos();
        return {5'(ml), 5'(mm), 5'(mr)};
    endfunction

    // ---------------- out_ready driver ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 0;
            end else begin
                if (bus.err) err_seen++;
                if (bus.out_valid) begin
                    if (!prev_vld) begin
                        if (sb.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL spurious_out: got letter %0d expected no output",
                                     bus.out_letter);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            chk("out_letter", int'(bus.out_letter), e.letter);
                            chk("latency", cyc - e.acc, 9);
                            chk("pos_at_out", int'(bus.pos), int'(e.pos));
                        end
                        held = int'(bus.out_letter);
                    end else begin
                        chk("out_hold", int'(bus.out_letter), held);
                    end
                end
                prev_vld = bus.out_valid;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready && !bus.out_valid && sb.size() == 0) ok = 1;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    task automatic handshake(input int code, output int acc);
        bit ok;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'(code);
        ok  = 0;
        acc = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok  = 1;
                acc = cyc;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // cletter=0 means take the expected letter from the model
    task automatic key(input int code, input logic [14:0] cpos, input bit use_cpos,
                       input int cletter);
        exp_t e;
        int   acc;
        wait_idle();
        model_step();
        e.letter = (cletter != 0) ? cletter : model_enc(code);
        e.pos    = use_cpos ? cpos : mpos();
        last_y   = e.letter;
        handshake(code, acc);
        e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic illegal(input int code);
        int acc;
        wait_idle();
        handshake(code, acc);
        err_exp++;
        @(negedge clk);
        @(negedge clk);
        chk("err_count", err_seen, err_exp);
        chk("pos_after_illegal", int'(bus.pos), int'(mpos()));
    endtask

    task automatic do_load(input logic [14:0] v);
        wait_idle();
        @(posedge clk);
        #1;
        bus.load     = 1'b1;
        bus.load_pos = v;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        ml = (v[14:10] > 5'd25) ? 0 : int'(v[14:10]);
        mm = (v[9:5]   > 5'd25) ? 0 : int'(v[9:5]);
        mr = (v[4:0]   > 5'd25) ? 0 : int'(v[4:0]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.in_letter = 5'd0;
        bus.load      = 1'b0;
        bus.load_pos  = 15'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_letter", int'(bus.out_letter), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_pos", int'(bus.pos), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // odometer carry and wrap without carry
        do_load({5'd0, 5'd0, 5'd21});
        key(1, {5'd0, 5'd1, 5'd22}, 1, 0);
        do_load({5'd0, 5'd0, 5'd25});
        key(2, {5'd0, 5'd0, 5'd0}, 1, 0);

        // middle rotor on its notch
        do_load({5'd0, 5'd3, 5'd21});
        key(3, {5'd0, 5'd4, 5'd22}, 1, 0);
`ifdef ENIGMA_DOUBLE_STEP_EN
        key(4, {5'd1, 5'd5, 5'd23}, 1, 0);
`else
        key(4, {5'd0, 5'd4, 5'd23}, 1, 0);
`endif

        // out-of-range load fields become 0
        do_load({5'd30, 5'd2, 5'd26});
        @(negedge clk);
        chk("load_clamp", int'(bus.pos), int'({5'd0, 5'd2, 5'd0}));

        // reciprocity
        do_load(15'd0);
        key(1, 15'd0, 0, 0);
        do_load(15'd0);
        key(last_y, 15'd0, 0, 1);

        illegal(0);
        illegal(27);

        // backpressure in DONE, with in_valid and load offered meanwhile
        wait_idle();
        rdy_mode = 0;
        key(7, 15'd0, 0, 0);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        chk("bp_out_valid_seen", int'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b1;
            bus.in_letter = 5'd9;
            bus.load      = 1'b1;
            bus.load_pos  = {5'd5, 5'd5, 5'd5};
            @(negedge clk);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_out_valid", int'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.load     = 1'b0;
        rdy_mode     = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", int'(bus.in_ready), 1);
        chk("bp_release_out_valid", int'(bus.out_valid), 0);
        chk("bp_load_ignored", int'(bus.pos), int'(mpos()));

        // reset while the letter is in FWD1
        do_load({5'd3, 5'd7, 5'd11});
        wait_idle();
        handshake(5, acc);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_pos", int'(bus.pos), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ml = 0;
        mm = 0;
        mr = 0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(bus.in_ready), 1);
        repeat (15) @(negedge clk);

        // random traffic with random lampboard stalls
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int r;
            int c;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_load({5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                         5'($urandom_range(0, 31))});
            end else if (r == 1) begin
                c = $urandom_range(0, 5);
                illegal((c == 0) ? 0 : 26 + c);
            end else begin
                key($urandom_range(1, 26), 15'd0, 0, 0);
            end
        end
        rdy_mode = 1;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("err_total", err_seen, err_exp);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
